uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Receive-side counterpart of the UART TX datapath. The block oversamples the serial line RX_IN, detects and validates the start bit, and shifts in 8 data bits LSB first. It then checks the optional parity bit against the same even/odd convention the TX parity calculator uses, and checks the stop bit. Each good byte is presented on P_DATA with a one-cycle DATA_VALID strobe, and parity and framing failures are flagged separately.

## Interface
- PRESCALE, 8: clock cycles per bit. Legal values are 8, 16 and 32.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idles high; asynchronous to CLK.
- PAR_EN  in  1  1 means a parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  8  last correctly received byte.
- DATA_VALID  out  1  one-cycle strobe when P_DATA is updated.
- PAR_ERR  out  1  one-cycle strobe when the received parity bit is wrong.
- STP_ERR  out  1  one-cycle strobe when the stop bit samples 0.

## Operation
- RX_IN passes through a 2-flop synchronizer. All further logic uses the synchronized value rx_s.
- Bit timing uses two counters:
  - tick counter, 0..PRESCALE-1;
  - bit counter, 0..7.
- Each bit value is the majority vote of rx_s taken at tick counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The vote decision is made at tick PRESCALE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - On rx_s = 0, clear the tick counter and go to START.
  - Latch PAR_EN and PAR_TYP at this point. Changes to either during a frame are ignored.
- START:
  - If the vote is 1, treat it as a glitch and return to IDLE with no strobe.
  - Otherwise go to DATA after tick PRESCALE-1.
- DATA:
  - Shift the vote into bit [bit counter] of an internal shift register.
  - After 8 bits, go to PARITY if the latched PAR_EN is 1, else go to STOP.
- PARITY: expected parity bit = (^data) ^ PAR_TYP. A mismatch sets an internal par_fail flag.
- STOP, at the decision tick:
  - vote 1 and no par_fail: P_DATA <= data, pulse DATA_VALID, go to IDLE.
  - vote 1 and par_fail: pulse PAR_ERR, P_DATA unchanged, go to IDLE.
  - vote 0: pulse STP_ERR (and also PAR_ERR if par_fail), go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE. A held-low line therefore produces exactly one STP_ERR.
- STOP exits at mid-bit, so a start bit that arrives back-to-back is never missed.

## Timing
- Reset values: P_DATA = 0x00, DATA_VALID = PAR_ERR = STP_ERR = 0, FSM = IDLE, all counters = 0.
- Reset asserted mid-frame aborts the frame immediately. No strobe is emitted, and the next frame is accepted normally.
- Strobes are registered and last exactly one CLK.
- Latency: the strobe rises in the cycle after the STOP decision tick, about (9 + PAR_EN)·PRESCALE + PRESCALE/2 + 4 cycles after the falling edge of RX_IN.
- Strobes are mutually exclusive, except that PAR_ERR and STP_ERR may assert together.
- P_DATA changes only in the cycle DATA_VALID rises.
- Tolerates a baud mismatch of up to ±3% accumulated over the frame.

## Structure
- Package uart_pkg:
  - state enum rx_state_t;
  - PAR_EVEN = 1'b0 and PAR_ODD = 1'b1, shared with the TX parity calculator;
  - DATA_BITS = 8.
- Sub-module uart_rx_sampler: synchronizer, tick counter and 3-sample majority vote. Outputs sample_bit, sample_done and bit_end.
- The top level holds the FSM, the bit counter, the shift register and the output registers.

## Test plan
All scenarios use PRESCALE = 8.
1. 0xA5, PAR_EN = 1, PAR_TYP = 0, parity bit 0 -> one DATA_VALID, P_DATA = 0xA5, no error strobes.
2. 0xA5, PAR_EN = 1, PAR_TYP = 1, parity bit sent as 0 -> one PAR_ERR, no DATA_VALID, P_DATA keeps its previous value.
3. 0x3C, PAR_EN = 0, stop bit forced to 0 and line then held low for 40 bit times -> exactly one STP_ERR. A later frame 0x01 -> DATA_VALID with P_DATA = 0x01.
4. RX_IN low pulse of 3 cycles while idle -> no strobes, FSM back in IDLE. A following frame 0xFF is received correctly.
5. Frames 0x00, then 0xFF, then 0x81 sent back-to-back with a 1-bit stop -> three DATA_VALID strobes with the matching P_DATA values.
6. RST pulsed low at data bit 4 of frame 0x55 -> all outputs reset to 0. The next frame 0x55 -> DATA_VALID with P_DATA = 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the RX frame receiver and TX parity logic.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: RX synchronizer, per-bit tick counter and 3-sample mid-bit majority vote.
module uart_rx_sampler #(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    input  logic run,
    output logic rx_s,
    output logic sample_bit,
    output logic sample_done,
    output logic bit_end
);
    localparam int TW = $clog2(PRESCALE);
    localparam logic [TW-1:0] T_A = TW'(PRESCALE / 2 - 1);
    localparam logic [TW-1:0] T_B = TW'(PRESCALE / 2);
    localparam logic [TW-1:0] T_C = TW'(PRESCALE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(PRESCALE - 1);

    logic rx_m, s0, s1;
    logic [TW-1:0] tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            tick <= '0;
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            tick <= (run && tick != T_LAST) ? tick + 1'b1 : '0;
            if (tick == T_A) s0 <= rx_s;
            if (tick == T_B) s1 <= rx_s;
        end
    end

    // third vote is the live sample at the decision tick
    assign sample_bit = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign sample_done = run && tick == T_C;
    assign bit_end = run && tick == T_LAST;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with optional even/odd parity and stop-bit checking.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       DATA_VALID,
    output logic       PAR_ERR,
    output logic       STP_ERR
);
    rx_state_t state;
    logic [$clog2(DATA_BITS)-1:0] bit_cnt;
    logic [DATA_BITS-1:0] data;
    logic par_fail, par_en_q, par_typ_q;
    logic run, rx_s, sample_bit, sample_done, bit_end;

    assign run = state inside {START, DATA, PARITY, STOP};

    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_smp (
        .clk(CLK),
        .rst_n(RST),
        .rx_in(RX_IN),
        .run(run),
        .rx_s(rx_s),
        .sample_bit(sample_bit),
        .sample_done(sample_done),
        .bit_end(bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            bit_cnt <= '0;
            data <= '0;
            par_fail <= 1'b0;
            par_en_q <= 1'b0;
            par_typ_q <= 1'b0;
            P_DATA <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR <= 1'b0;
            STP_ERR <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR <= 1'b0;
            STP_ERR <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    par_en_q <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    par_fail <= 1'b0;
                    bit_cnt <= '0;
                end
                START: begin
                    if (sample_done && sample_bit) state <= IDLE;
                    else if (bit_end) state <= DATA;
                end
                DATA: begin
                    if (sample_done) data[bit_cnt] <= sample_bit;
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == $bits(bit_cnt)'(DATA_BITS - 1)) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sample_done) par_fail <= sample_bit != ((^data) ^ par_typ_q);
                    if (bit_end) state <= STOP;
                end
                // leave at mid-bit so a back-to-back start edge is seen from IDLE
                STOP: if (sample_done) begin
                    if (sample_bit) begin
                        state <= IDLE;
                        PAR_ERR <= par_fail;
                        DATA_VALID <= !par_fail;
                        if (!par_fail) P_DATA <= data;
                    end else begin
                        state <= BREAK;
                        STP_ERR <= 1'b1;
                        PAR_ERR <= par_fail;
                    end
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames at PRESCALE = 8 with strobe counting and hand-computed expectations.
module tb_uart_rx_frame;
    import uart_pkg::*;
    localparam int PS = 8;

    logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic DATA_VALID, PAR_ERR, STP_ERR;

    int n_tests = 0, n_fail = 0;
    int n_dv = 0, n_pe = 0, n_se = 0;
    int s_dv, s_pe, s_se, k;
    logic [7:0] dv_log [0:31];

    uart_rx_frame #(.PRESCALE(PS)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR),
        .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            dv_log[n_dv[4:0]] <= P_DATA;
            n_dv <= n_dv + 1;
        end
        if (PAR_ERR) n_pe <= n_pe + 1;
        if (STP_ERR) n_se <= n_se + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (PS) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        send_bit(sb);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic snap();
        s_dv = n_dv;
        s_pe = n_pe;
        s_se = n_se;
    endtask

    task automatic expect_counts(input string tag, input int dv, input int pe, input int se);
        check({tag, "_dv"}, 32'(n_dv - s_dv), 32'(dv));
        check({tag, "_pe"}, 32'(n_pe - s_pe), 32'(pe));
        check({tag, "_se"}, 32'(n_se - s_se), 32'(se));
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_pdata", 32'(P_DATA), 32'h00);
        check("rst_strobes", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_tick", 32'(dut.u_smp.tick), 32'd0);
        RST = 1'b1;
        idle(4);

        // even parity of 0xA5 (four ones) is 0
        PAR_EN = 1'b1; PAR_TYP = PAR_EVEN;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle(24);
        expect_counts("t1", 1, 0, 0);
        check("t1_pdata", 32'(P_DATA), 32'hA5);

        PAR_TYP = PAR_ODD;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle(24);
        expect_counts("t2", 0, 1, 0);
        check("t2_pdata", 32'(P_DATA), 32'hA5);

        PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40 * PS) @(negedge CLK);
        check("t3_break", 32'(dut.state), 32'(BREAK));
        idle(2 * PS);
        expect_counts("t3", 0, 0, 1);
        check("t3_pdata_kept", 32'(P_DATA), 32'hA5);
        snap();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        idle(24);
        expect_counts("t3b", 1, 0, 0);
        check("t3b_pdata", 32'(P_DATA), 32'h01);

        snap();
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        idle(3 * PS);
        expect_counts("t4", 0, 0, 0);
        check("t4_state", 32'(dut.state), 32'(IDLE));
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle(24);
        check("t4b_dv", 32'(n_dv - s_dv), 32'd1);
        check("t4b_pdata", 32'(P_DATA), 32'hFF);

        snap();
        k = n_dv;
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(24);
        expect_counts("t5", 3, 0, 0);
        check("t5_b0", 32'(dv_log[k[4:0]]), 32'h00);
        check("t5_b1", 32'(dv_log[5'(k + 1)]), 32'hFF);
        check("t5_b2", 32'(dv_log[5'(k + 2)]), 32'h81);

        // abort 0x55 halfway through data bit 4
        snap();
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        RX_IN = 1'b1;
        repeat (PS / 2) @(negedge CLK);
        check("t6_mid", 32'(dut.state), 32'(DATA));
        RST = 1'b0;
        @(negedge CLK);
        check("t6_rst_pdata", 32'(P_DATA), 32'h00);
        check("t6_rst_state", 32'(dut.state), 32'(IDLE));
        check("t6_rst_bitcnt", 32'(dut.bit_cnt), 32'd0);
        RST = 1'b1;
        idle(2 * PS);
        expect_counts("t6", 0, 0, 0);
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        idle(24);
        expect_counts("t6b", 1, 0, 0);
        check("t6b_pdata", 32'(P_DATA), 32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
